// File: rtl/pipelined_alu_md.sv
// pipelined_alu_md: integer ALU with the RV M-extension ops behind valid/ready
// handshakes. Base ops finish one cycle after accept. MUL*/DIV*/REM* run on an
// iterative shift-add / restoring-divide datapath over XLEN CALC cycles.
// Division by zero and signed overflow are resolved at accept without CALC.
//
// Build option: define FAST_MUL_EN to use a combinational multiplier for ops
// 11-14, which then also finish one cycle after accept. Divides stay iterative.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   op/a/b presented        in_ready   op accepted this cycle
//   op[4:0]    operation code          a, b       XLEN-bit operands
//   out_valid  result valid            out_ready  consumer takes result
//   result     registered result       zero       registered result == 0
//   lt         registered compare flag busy       high while in CALC
module pipelined_alu_md #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            lt,
  output logic            busy
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,  OP_SUB    = 5'd1,  OP_AND   = 5'd2,  OP_OR    = 5'd3,
    OP_JALR   = 5'd4,  OP_SLT    = 5'd5,  OP_XOR   = 5'd6,  OP_SLL   = 5'd7,
    OP_SRL    = 5'd8,  OP_SRA    = 5'd9,  OP_SLTU  = 5'd10, OP_MUL   = 5'd11,
    OP_MULH   = 5'd12, OP_MULHSU = 5'd13, OP_MULHU = 5'd14, OP_DIV   = 5'd15,
    OP_DIVU   = 5'd16, OP_REM    = 5'd17, OP_REMU  = 5'd18
  } op_e;

  state_e state_q, state_d;

  logic [SHW-1:0]  cnt_q, cnt_d;
  logic [4:0]      op_q, op_d;
  logic [XLEN-1:0] hi_q, hi_d;        // product high half / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;        // multiplier / dividend, becomes low half / quotient
  logic [XLEN-1:0] mcand_q, mcand_d;  // multiplicand / divisor
  logic            neg_q, neg_d;      // negate the final value (sign fixup)
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;
  logic            lt_q, lt_d;

  logic accept;
  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------- operand decode
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_mul_in, is_div_in, div_zero, div_ovf, iter_in;

  assign a_neg     = a[XLEN-1];
  assign b_neg     = b[XLEN-1];
  assign a_mag     = a_neg ? ('0 - a) : a;
  assign b_mag     = b_neg ? ('0 - b) : b;
  assign is_mul_in = (op >= OP_MUL) && (op <= OP_MULHU);
  assign is_div_in = (op >= OP_DIV) && (op <= OP_REMU);
  assign div_zero  = (b == '0);
  assign div_ovf   = ((op == OP_DIV) || (op == OP_REM)) &&
                     (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

`ifdef FAST_MUL_EN
  assign iter_in = is_div_in && !div_zero && !div_ovf;
`else
  assign iter_in = is_mul_in || (is_div_in && !div_zero && !div_ovf);
`endif

`ifdef FAST_MUL_EN
  logic                sa, sb;
  logic [2*XLEN+1:0]   fa, fb, fprod;
  assign sa    = ((op == OP_MULH) || (op == OP_MULHSU)) && a_neg;
  assign sb    = (op == OP_MULH) && b_neg;
  assign fa    = {{(XLEN+2){sa}}, a};
  assign fb    = {{(XLEN+2){sb}}, b};
  assign fprod = fa * fb;
`endif

  // ---------------------------------------------------------------- single-cycle results
  logic [XLEN-1:0] sum_ab, imm_res;
  logic [SHW-1:0]  shamt;
  logic            slt_s, slt_u, imm_lt;

  assign sum_ab = a + b;
  assign shamt  = b[SHW-1:0];
  assign slt_s  = $signed(a) < $signed(b);
  assign slt_u  = a < b;

  always_comb begin
    imm_res = '0;
    imm_lt  = 1'b0;
    case (op)
      OP_ADD:  imm_res = sum_ab;
      OP_SUB:  begin imm_res = a - b; imm_lt = slt_s; end
      OP_AND:  imm_res = a & b;
      OP_OR:   imm_res = a | b;
      OP_JALR: imm_res = {sum_ab[XLEN-1:1], 1'b0};
      OP_SLT:  begin imm_res = {{(XLEN-1){1'b0}}, slt_s}; imm_lt = slt_s; end
      OP_XOR:  imm_res = a ^ b;
      OP_SLL:  imm_res = a << shamt;
      OP_SRL:  imm_res = a >> shamt;
      OP_SRA:  imm_res = $unsigned($signed(a) >>> shamt);
      OP_SLTU: begin imm_res = {{(XLEN-1){1'b0}}, slt_u}; imm_lt = slt_u; end
`ifdef FAST_MUL_EN
      OP_MUL:                       imm_res = fprod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: imm_res = fprod[2*XLEN-1:XLEN];
`endif
      OP_DIV, OP_DIVU: imm_res = div_zero ? '1 : a;   // only reached for special cases
      OP_REM, OP_REMU: imm_res = div_zero ? a : '0;
      default: imm_res = '0;
    endcase
  end

  // Iterative operands: magnitudes go in, neg records the final sign fixup.
  logic [XLEN-1:0] ld_lo, ld_mc;
  logic            ld_neg;

  always_comb begin
    ld_lo  = a;
    ld_mc  = b;
    ld_neg = 1'b0;
    case (op)
      OP_MULH, OP_DIV: begin ld_lo = a_mag; ld_mc = b_mag; ld_neg = a_neg ^ b_neg; end
      OP_MULHSU:       begin ld_lo = a_mag; ld_neg = a_neg; end
      OP_REM:          begin ld_lo = a_mag; ld_mc = b_mag; ld_neg = a_neg; end
      default:         ;
    endcase
  end

  // ---------------------------------------------------------------- iteration step
  logic            op_q_div, last;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic            q_bit;
  logic [XLEN-1:0] hi_n, lo_n;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0] quo_s, rem_s, fin_res;

  assign op_q_div = (op_q >= OP_DIV);
  assign last     = (cnt_q == SHW'(XLEN-1));
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
  assign div_sh   = {hi_q, lo_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, mcand_q};
  assign q_bit    = ~div_diff[XLEN];

  always_comb begin
    if (op_q_div) begin
      hi_n = q_bit ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], q_bit};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo_q[XLEN-1:1]};
    end
  end

  // The last step's outcome is sign-fixed and written straight into result.
  assign prod   = {hi_n, lo_n};
  assign prod_s = neg_q ? ('0 - prod) : prod;
  assign quo_s  = neg_q ? ('0 - lo_n) : lo_n;
  assign rem_s  = neg_q ? ('0 - hi_n) : hi_n;

  always_comb begin
    fin_res = '0;
    case (op_q)
      OP_MUL:                       fin_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = quo_s;
      OP_REM, OP_REMU:              fin_res = rem_s;
      default:                      fin_res = '0;
    endcase
  end

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = iter_in ? S_CALC : S_DONE;
      S_CALC: if (last)   state_d = S_DONE;
      S_DONE: begin
        if (accept)         state_d = iter_in ? S_CALC : S_DONE;
        else if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_CALC);
  end

  // ---------------------------------------------------------------- datapath
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    result_d = result_q;
    zero_d   = zero_q;
    lt_d     = lt_q;
    if (accept) begin
      op_d    = op;
      cnt_d   = '0;
      hi_d    = '0;
      lo_d    = ld_lo;
      mcand_d = ld_mc;
      neg_d   = ld_neg;
      if (!iter_in) begin
        result_d = imm_res;
        zero_d   = (imm_res == '0);
        lt_d     = imm_lt;
      end
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q + 1'b1;
      hi_d  = hi_n;
      lo_d  = lo_n;
      if (last) begin
        result_d = fin_res;
        zero_d   = (fin_res == '0);
        lt_d     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      op_q     <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
      lt_q     <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      lt_q     <= lt_d;
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign lt     = lt_q;

endmodule

// File: tb/tb_pipelined_alu_md.sv
module tb_pipelined_alu_md;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero, lt, busy;

  int vectors = 0;
  int miscompares = 0;
  int lat;
  int busy_low;

`ifdef FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif

  always #5 clk = ~clk;

  pipelined_alu_md #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .lt(lt), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present an op, wait for accept, then count cycles until out_valid.
  // Latency 1 means out_valid is seen right after the accept edge.
  task automatic run_op(input logic [4:0] o, input logic [31:0] aa, input logic [31:0] bb);
    int w;
    op = o; a = aa; b = bb; in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin tick(); w++; end
    tick();
    in_valid = 1'b0;
    lat = 1;
    busy_low = 0;
    while (!out_valid && lat < 200) begin
      if (!busy) busy_low++;
      tick();
      lat++;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1;
    #1;
    chk("rst_result", result, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_zero_lt", {30'b0, zero, lt}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk); reset = 1'b0;
    tick();

    // Base ops
    run_op(5'd1, 32'd5, 32'd7);
    chk("sub_lat", lat, 1);
    chk("sub_res", result, 32'hFFFFFFFE);
    chk("sub_lt_zero", {30'b0, lt, zero}, 32'h2);
    run_op(5'd10, 32'd5, 32'hFFFFFFFF);
    chk("sltu_res", result, 32'h1);
    chk("sltu_lt", {31'b0, lt}, 32'h1);
    run_op(5'd9, 32'h80000000, 32'h24);
    chk("sra_res", result, 32'hF8000000);
    chk("sra_lt", {31'b0, lt}, 32'h0);
    run_op(5'd4, 32'h1001, 32'h2);
    chk("jalr_res", result, 32'h1002);
    run_op(5'd5, 32'hFFFFFFFF, 32'h1);
    chk("slt_res", result, 32'h1);
    chk("slt_lt", {31'b0, lt}, 32'h1);
    run_op(5'd7, 32'h1, 32'h21);
    chk("sll_res", result, 32'h2);
    run_op(5'd8, 32'h80000000, 32'd31);
    chk("srl_res", result, 32'h1);
    run_op(5'd6, 32'hFF00FF00, 32'h0FF00FF0);
    chk("xor_res", result, 32'hF0F0F0F0);
    run_op(5'd25, 32'h12345678, 32'h1);
    chk("illegal_lat", lat, 1);
    chk("illegal_res", result, 32'h0);
    chk("illegal_zero", {31'b0, zero}, 32'h1);

    // Multiply
    run_op(5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mulh_lat", lat, MUL_LAT);
    chk("mulh_busy", busy_low, 0);
    chk("mulh_res", result, 32'h0);
    chk("mulh_zero", {31'b0, zero}, 32'h1);
    run_op(5'd14, 32'hFFFFFFFF, 32'hFFFFFFFF);
    chk("mulhu_lat", lat, MUL_LAT);
    chk("mulhu_res", result, 32'hFFFFFFFE);
    chk("mulhu_zero", {31'b0, zero}, 32'h0);
    run_op(5'd11, 32'd7, 32'hFFFFFFFD);
    chk("mul_res", result, 32'hFFFFFFEB);
    run_op(5'd13, 32'hFFFFFFFF, 32'd2);
    chk("mulhsu_res", result, 32'hFFFFFFFF);

    // Divide
    run_op(5'd15, 32'hFFFFFFF9, 32'd2);
    chk("div_lat", lat, 33);
    chk("div_busy", busy_low, 0);
    chk("div_res", result, 32'hFFFFFFFD);
    run_op(5'd17, 32'hFFFFFFF9, 32'd2);
    chk("rem_res", result, 32'hFFFFFFFF);
    run_op(5'd16, 32'd100, 32'd7);
    chk("divu_res", result, 32'd14);
    run_op(5'd18, 32'd100, 32'd7);
    chk("remu_res", result, 32'd2);
    run_op(5'd16, 32'd9, 32'd0);
    chk("divu0_lat", lat, 1);
    chk("divu0_res", result, 32'hFFFFFFFF);
    run_op(5'd18, 32'd9, 32'd0);
    chk("remu0_res", result, 32'd9);
    run_op(5'd15, 32'h80000000, 32'hFFFFFFFF);
    chk("divovf_lat", lat, 1);
    chk("divovf_res", result, 32'h80000000);
    run_op(5'd17, 32'h80000000, 32'hFFFFFFFF);
    chk("removf_res", result, 32'h0);

    // Backpressure then back-to-back accept
    tick();
    out_ready = 1'b0;
    run_op(5'd0, 32'd1, 32'd2);
    chk("bp_lat", lat, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_res", result, 32'd3);
      chk("bp_hold_ready", {30'b0, in_ready, out_valid}, 32'h1);
    end
    out_ready = 1'b1;
    op = 5'd2; a = 32'h0000F0F0; b = 32'h0000FF00; in_valid = 1'b1;
    #1;
    chk("b2b_in_ready", {31'b0, in_ready}, 32'h1);
    tick();
    in_valid = 1'b0;
    chk("b2b_valid", {31'b0, out_valid}, 32'h1);
    chk("b2b_res", result, 32'h0000F000);
    tick();
    chk("b2b_idle", {31'b0, out_valid}, 32'h0);

    // Reset mid-CALC
    op = 5'd16; a = 32'd100; b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("calc_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_flags", {27'b0, busy, out_valid, zero, lt, in_ready}, 32'h1);
    @(negedge clk); reset = 1'b0;
    tick();
    chk("post_rst_busy", {31'b0, busy}, 32'h0);
    run_op(5'd0, 32'd7, 32'd8);
    chk("post_rst_lat", lat, 1);
    chk("post_rst_res", result, 32'd15);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipelined_alu_md.md
Name: pipelined_alu_md

Overview:
Parametrised successor to the single-cycle integer ALU, for the multi-cycle core.
- Executes the base RV integer ALU ops plus the RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) at width XLEN.
- Operands enter and results leave through valid/ready handshakes.
- Multiply and divide run on an iterative shift-add / restoring-divide datapath.
- Sits between the decode/operand-read stage and writeback; the core stalls on in_ready.

Parameters:
- XLEN, 32, operand/result width; must be at least 8 and a power of two.
- SHW, $clog2(XLEN), localparam; shift-amount and iteration-counter width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and op presented.
- in_ready  output  1  block accepts an op this cycle.
- op  input  5  operation code (see Behaviour).
- a  input  XLEN  operand A.
- b  input  XLEN  operand B.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer takes the result.
- result  output  XLEN  registered result.
- zero  output  1  registered: result == 0.
- lt  output  1  registered compare flag for branches.
- busy  output  1  high in CALC state.

Behaviour:
- Op codes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR.
  - 4 JALR target: (a+b) with bit 0 cleared.
  - 5 SLT, 6 XOR, 7 SLL, 8 SRL, 9 SRA, 10 SLTU.
  - 11 MUL, 12 MULH, 13 MULHSU, 14 MULHU, 15 DIV, 16 DIVU, 17 REM, 18 REMU.
  - 19-31 illegal: result 0.
- Shifts use b[SHW-1:0] only. SLT/SLTU return 1 or 0, zero-extended.
- lt:
  - ops 1 and 5: signed a<b.
  - op 10: unsigned a<b.
  - all other ops: 0.
- Accept: in_valid && in_ready captures op, a and b.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Back-to-back accepts are allowed.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - CALC: busy=1, in_ready=0. Iteration counter runs 0..XLEN-1. On count==XLEN-1, go to DONE.
  - DONE: out_valid=1. result, zero and lt are held stable until out_ready.
  - DONE with out_ready and a new accept: move to DONE or CALC for the new op.
  - DONE with out_ready and no accept: move to IDLE.
- Latency, measured from the accept edge to out_valid:
  - Base ops and illegal ops: 1 cycle.
  - MUL*/DIV*/REM*: XLEN+1 cycles.
- Division special cases skip CALC and complete in 1 cycle:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give a.
  - Signed overflow (a = 1<<(XLEN-1), b = all-ones): DIV gives a; REM gives 0.
- Signed divide: operate on magnitudes.
  - Quotient is negated when sign(a) != sign(b).
  - Remainder takes the sign of a.
- MULH/MULHSU/MULHU return the upper XLEN bits of the 2*XLEN product, with signed/unsigned per RV spec. MUL returns the lower XLEN bits.
- in_valid while in CALC: not accepted. Operands are not sampled.
- out_ready while out_valid=0: ignored.
- Reset (asynchronous, any state including mid-CALC) forces:
  - state IDLE, counter 0.
  - result 0, zero 0, lt 0, out_valid 0, busy 0.
  - The in-flight op is discarded.

Optional Feature:
- Macro: FAST_MUL_EN.
- Defined: ops 11-14 use a combinational 2*XLEN multiplier, complete with 1-cycle latency and never enter CALC. Divide ops remain iterative.
- Undefined: all multiply ops are iterative, XLEN+1 latency.

Test Plan:
- SUB, a=5, b=7, out_ready=1 -> out_valid the next cycle; result=0xFFFFFFFE, lt=1, zero=0. Then SLTU, a=5, b=0xFFFFFFFF -> result=1, lt=1.
- SRA, a=0x80000000, b=0x24 (shamt 4) -> result=0xF8000000. JALR, a=0x1001, b=2 -> result=0x1002.
- MULH, a=0xFFFFFFFF, b=0xFFFFFFFF -> result=0, zero=1. MULHU with the same operands -> result=0xFFFFFFFE. out_valid exactly 33 cycles after accept (1 cycle if FAST_MUL_EN); busy high throughout CALC.
- DIV, a=-7, b=2 -> result=0xFFFFFFFD. REM with the same operands -> result=0xFFFFFFFF. DIVU, a=9, b=0 -> result=0xFFFFFFFF in 1 cycle. DIV, a=0x80000000, b=-1 -> result=0x80000000.
- Backpressure: hold out_ready=0 for 5 cycles after ADD, a=1, b=2 -> result stays 3, in_ready=0. Raise out_ready together with a new in_valid AND -> new result on the following cycle, no bubble.
- Assert reset at CALC cycle 10 of DIVU -> outputs immediately 0, state IDLE. A subsequent ADD completes normally with 1-cycle latency.
